// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the 640x480@60 Hz VGA path.
//   HACTIVE/VACTIVE : visible pixels per line / visible lines per frame
//   HTOTAL/VTOTAL   : full line / frame lengths of the sync generator
//   mstate_t        : motion scheduler FSM states
package vga_pkg;

  localparam int HACTIVE = 640;
  localparam int VACTIVE = 480;
  localparam int HTOTAL  = 800;
  localparam int VTOTAL  = 525;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } mstate_t;

endpackage

// File: rtl/motion_axis.sv
// motion_axis: next position / direction of one sprite axis.
//   pos, dir   : current committed position and direction (1 = increasing)
//   max        : largest legal position (screen extent minus sprite extent)
//   speed      : pixels moved per update
//   next_pos   : position after one update
//   next_dir   : direction after one update
// Build option MOTION_WRAP_EN: the sprite wraps to the opposite edge
// instead of bouncing, and the direction never changes.
module motion_axis (
  input  logic [9:0] pos,
  input  logic       dir,
  input  logic [9:0] max,
  input  logic [3:0] speed,
  output logic [9:0] next_pos,
  output logic       next_dir
);

  // One extra bit so pos+speed near the right/bottom edge cannot overflow.
  logic [10:0] pos_e, max_e, spd_e, inc;
  logic [9:0]  dec;

  assign pos_e = {1'b0, pos};
  assign max_e = {1'b0, max};
  assign spd_e = {7'd0, speed};
  assign inc   = pos_e + spd_e;
  assign dec   = pos - {6'd0, speed};

  always_comb begin
    next_pos = pos;
    next_dir = dir;
`ifdef MOTION_WRAP_EN
    if (dir) next_pos = (inc > max_e) ? 10'd0 : inc[9:0];
    else     next_pos = (pos_e < spd_e) ? max : dec;
`else
    if (dir) begin
      if (inc >= max_e) begin
        next_pos = max;
        next_dir = 1'b0;
      end else begin
        next_pos = inc[9:0];
      end
    end else begin
      if (pos_e <= spd_e) begin
        next_pos = 10'd0;
        next_dir = 1'b1;
      end else begin
        next_pos = dec;
      end
    end
`endif
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: frame-locked motion scheduler for one sprite.
//   clk        : pixel clock
//   rst_n      : asynchronous active-low reset
//   hc, vc     : sync generator counters
//   run        : 1 = move every FRAME_DIV frames, 0 = paused
//   step_req   : single-step request (rising edge while paused)
//   step_ack   : pulse when a stepped update commits
//   sprite_x/y : committed top-left corner
//   dir_x/y    : committed direction, 1 = increasing coordinate
//   frame_tick : pulse on every commit
//   in_sprite  : registered (hc,vc) inside the committed box
// Position updates happen only during vertical blanking, so the
// pixel-colour logic never sees a position change mid-frame.
// Build option MOTION_WRAP_EN selects wrap-around instead of bounce.
module sprite_motion_ctrl #(
  parameter int SPR_W     = 130,
  parameter int SPR_H     = 42,
  parameter int SPEED     = 1,
  parameter int FRAME_DIV = 1,
  parameter int X0        = 0,
  parameter int Y0        = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       run,
  input  logic       step_req,
  output logic       step_ack,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       frame_tick,
  output logic       in_sprite
);
  import vga_pkg::*;

  localparam logic [9:0] XMAX    = 10'(HACTIVE - SPR_W);
  localparam logic [9:0] YMAX    = 10'(VACTIVE - SPR_H);
  localparam logic [3:0] SPD     = 4'(SPEED);
  localparam logic [7:0] FD_LAST = 8'(FRAME_DIV - 1);
  localparam logic [9:0] X_RST   = 10'(X0);
  localparam logic [9:0] Y_RST   = 10'(Y0);

  mstate_t    state;
  logic       vb_evt;
  logic [7:0] frame_cnt;
  logic       step_req_q, step_pend, from_step;
  logic [9:0] shadow_x, shadow_y;
  logic       shadow_dx, shadow_dy;
  logic [9:0] nx, ny;
  logic       ndx, ndy;
  logic       due, step_rise;

  motion_axis u_axis_x (
    .pos(sprite_x), .dir(dir_x), .max(XMAX), .speed(SPD),
    .next_pos(nx), .next_dir(ndx)
  );

  motion_axis u_axis_y (
    .pos(sprite_y), .dir(dir_y), .max(YMAX), .speed(SPD),
    .next_pos(ny), .next_dir(ndy)
  );

  // frame_cnt still holds its pre-increment value on the vb_evt cycle,
  // so "about to wrap" marks the due frame.
  assign due       = (frame_cnt == FD_LAST) && (run || step_pend);
  assign step_rise = step_req && !step_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_evt     <= 1'b0;
      frame_cnt  <= 8'd0;
      step_req_q <= 1'b0;
      step_pend  <= 1'b0;
    end else begin
      vb_evt     <= (hc == 10'd0) && (vc == 10'(VACTIVE));
      step_req_q <= step_req;
      if (vb_evt) frame_cnt <= (frame_cnt == FD_LAST) ? 8'd0 : frame_cnt + 8'd1;
      // A fresh request arriving on the commit edge survives the clear.
      if (step_rise && !run)              step_pend <= 1'b1;
      else if (state == CALC && from_step) step_pend <= 1'b0;
    end
  end

  // Shadow is captured on entry to CALC from the committed position and
  // copied to the outputs on the CALC->COMMIT edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow_x   <= X_RST;
      shadow_y   <= Y_RST;
      shadow_dx  <= 1'b1;
      shadow_dy  <= 1'b1;
      from_step  <= 1'b0;
      sprite_x   <= X_RST;
      sprite_y   <= Y_RST;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      frame_tick <= 1'b0;
      step_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_tick <= 1'b0;
          step_ack   <= 1'b0;
          if (vb_evt && due) begin
            state     <= CALC;
            shadow_x  <= nx;
            shadow_y  <= ny;
            shadow_dx <= ndx;
            shadow_dy <= ndy;
            from_step <= step_pend;
          end
        end
        CALC: begin
          state      <= COMMIT;
          sprite_x   <= shadow_x;
          sprite_y   <= shadow_y;
          dir_x      <= shadow_dx;
          dir_y      <= shadow_dy;
          frame_tick <= 1'b1;
          step_ack   <= from_step;
        end
        COMMIT: begin
          state      <= IDLE;
          frame_tick <= 1'b0;
          step_ack   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0] hc_e, vc_e, x_e, y_e;
  assign hc_e = {1'b0, hc};
  assign vc_e = {1'b0, vc};
  assign x_e  = {1'b0, sprite_x};
  assign y_e  = {1'b0, sprite_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_sprite <= 1'b0;
    else        in_sprite <= (hc_e >= x_e) && (hc_e < x_e + 11'(SPR_W)) &&
                             (vc_e >= y_e) && (vc_e < y_e + 11'(SPR_H));
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
module tb_sprite_motion_ctrl;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
    logic       ack;
  } exp_t;

  logic       clk = 1'b0;
  logic [9:0] hc, vc, hc_s, vc_s;
  logic       rst_a_n, run_a, step_a;
  logic       rst_b_n, run_b, step_b;
  logic       ack_a, dxa, dya, ft_a, ins_a;
  logic       ack_b, dxb, dyb, ft_b, ins_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       probe, probe_d;

  exp_t qa[$];
  exp_t qb[$];
  logic iq[$];
  int   checks = 0;
  int   errors = 0;

  always #20 clk = ~clk;

  // Instance A: default parameters.
  sprite_motion_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .hc(hc), .vc(vc), .run(run_a), .step_req(step_a),
    .step_ack(ack_a), .sprite_x(x_a), .sprite_y(y_a), .dir_x(dxa), .dir_y(dya),
    .frame_tick(ft_a), .in_sprite(ins_a)
  );

  // Instance B: fast, divided, starting near the right edge with a short
  // vertical range (YMAX = 480-474 = 6).
  sprite_motion_ctrl #(
    .SPR_W(130), .SPR_H(474), .SPEED(4), .FRAME_DIV(3), .X0(508), .Y0(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .hc(hc), .vc(vc), .run(run_b), .step_req(step_b),
    .step_ack(ack_b), .sprite_x(x_b), .sprite_y(y_b), .dir_x(dxb), .dir_y(dyb),
    .frame_tick(ft_b), .in_sprite(ins_b)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Counter values the DUT saw on the most recent edge.
  always @(posedge clk) begin
    hc_s    <= hc;
    vc_s    <= vc;
    probe_d <= probe;
  end

  // Monitor: pops an expectation whenever a commit or a probe result shows.
  always @(negedge clk) begin
    exp_t e;
    if (ft_a) begin
      if (qa.size() == 0) chk("a_unexpected_tick", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_x", x_a, e.x);   chk("a_y", y_a, e.y);
        chk("a_dx", dxa, e.dx); chk("a_dy", dya, e.dy);
        chk("a_ack", ack_a, e.ack);
        chk("a_commit_hc", hc_s, 2); chk("a_commit_vc", vc_s, 480);
      end
    end
    if (ack_a && !ft_a) chk("a_stray_ack", 1, 0);
    if (ft_b) begin
      if (qb.size() == 0) chk("b_unexpected_tick", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_x", x_b, e.x);   chk("b_y", y_b, e.y);
        chk("b_dx", dxb, e.dx); chk("b_dy", dyb, e.dy);
        chk("b_ack", ack_b, e.ack);
        chk("b_commit_hc", hc_s, 2);
      end
    end
    if (probe_d) begin
      if (iq.size() == 0) chk("a_probe_underflow", 1, 0);
      else chk("a_in_sprite", ins_a, iq.pop_front());
    end
  end

  task automatic drive(input int v, input int h);
    @(posedge clk); #1;
    vc = 10'(v);
    hc = 10'(h);
  endtask

  // Compressed frame: only the counter values around the vblank event matter.
  task automatic frame();
    drive(479, 700); drive(479, 701);
    for (int i = 0; i < 10; i++) drive(480, i);
    drive(481, 100); drive(481, 101);
  endtask

  task automatic pulse_a();
    step_a = 1'b1;
    drive(300, 600); drive(300, 601);
    step_a = 1'b0;
    drive(300, 602);
  endtask

  task automatic push_a(input int x, input int y, input logic ack);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.dx = 1'b1; e.dy = 1'b1; e.ack = ack;
    qa.push_back(e);
  endtask

  task automatic push_b(input int x, input int y, input logic dx, input logic dy);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.dx = dx; e.dy = dy; e.ack = 1'b0;
    qb.push_back(e);
  endtask

  task automatic probe_at(input int h, input int v, input logic exp);
    drive(v, h);
    iq.push_back(exp);
    probe = 1'b1;
  endtask

  initial begin
    hc = 10'd700; vc = 10'd479;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    run_a = 1'b0; step_a = 1'b0; run_b = 1'b0; step_b = 1'b0;
    probe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_x", x_a, 0);      chk("rst_a_y", y_a, 0);
    chk("rst_a_dx", dxa, 1);     chk("rst_a_dy", dya, 1);
    chk("rst_a_tick", ft_a, 0);  chk("rst_a_ack", ack_a, 0);
    chk("rst_a_in", ins_a, 0);
    chk("rst_b_x", x_b, 508);    chk("rst_b_y", y_b, 2);
    rst_a_n = 1'b1;

    // Free run: one commit per frame.
    run_a = 1'b1;
    push_a(1, 1, 0); push_a(2, 2, 0); push_a(3, 3, 0);
    repeat (3) frame();

    // Reset while the update is in CALC: no tick, position back to reset.
    drive(479, 700); drive(480, 0); drive(480, 1);
    @(posedge clk); #1;
    rst_a_n = 1'b0;
    #1;
    chk("rstcalc_x", x_a, 0); chk("rstcalc_y", y_a, 0);
    chk("rstcalc_tick", ft_a, 0);
    drive(480, 3); drive(480, 4);
    rst_a_n = 1'b1;
    run_a = 1'b0;
    drive(480, 5); drive(480, 6); drive(481, 100);

    // Paused stepping: two pulses over five frames give two commits.
    pulse_a(); push_a(1, 1, 1); frame();
    frame();
    pulse_a(); push_a(2, 2, 1); frame();
    frame(); frame();
    // Request held high for five frames: a single commit.
    step_a = 1'b1;
    push_a(3, 3, 1);
    repeat (5) frame();
    step_a = 1'b0;
    drive(300, 0);
    // Pending step with run raised: one update, acknowledged.
    pulse_a(); run_a = 1'b1; push_a(4, 4, 1); frame();
    push_a(5, 5, 0); frame();
    // Step request while running is ignored: nothing left pending.
    pulse_a(); push_a(6, 6, 0); frame();
    run_a = 1'b0;
    frame();

    // Box at (6,6), 130x42: x 6..135, y 6..47.
    probe_at(6, 6, 1'b1);
    probe_at(5, 6, 1'b0);
    probe_at(135, 47, 1'b1);
    probe_at(136, 47, 1'b0);
    probe_at(135, 48, 1'b0);
    probe_at(100, 5, 1'b0);
    @(posedge clk); #1;
    probe = 1'b0; hc = 10'd700; vc = 10'd479;

    // Instance B: commits on every third vblank only.
    rst_b_n = 1'b1;
    run_b = 1'b1;
`ifdef MOTION_WRAP_EN
    push_b(0, 6, 1, 1); push_b(4, 0, 1, 1); push_b(8, 4, 1, 1);
`else
    push_b(510, 6, 0, 0); push_b(506, 2, 0, 0); push_b(502, 0, 0, 1);
`endif
    repeat (9) frame();
    run_b = 1'b0;
    repeat (4) drive(300, 0);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("probe_queue_drained", iq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous motion scheduler for one rectangular sprite on the 640x480@60 Hz VGA path. Watches the sync generator's pixel counters, advances the sprite position once per N frames during vertical blanking, bounces it off the screen edges, and presents tear-free position registers to the pixel-colour logic. Replaces free-running clock-count animation with updates locked to the frame.

## Interface
- HACTIVE, 640, visible pixels per line
- VACTIVE, 480, visible lines per frame
- SPR_W, 130, sprite width in pixels
- SPR_H, 42, sprite height in lines
- SPEED, 1, pixels moved per axis per update, 1..15
- FRAME_DIV, 1, frames per update, 1..255
- X0 / Y0, 0 / 0, position after reset
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous, active-low reset
- hc  in  10  horizontal counter from sync generator, 0..799
- vc  in  10  vertical counter from sync generator, 0..524
- run  in  1  1 = move every FRAME_DIV frames; 0 = paused
- step_req  in  1  single-step request, level, honoured while paused
- step_ack  out  1  one-cycle pulse when a stepped update commits
- sprite_x  out  10  committed left edge
- sprite_y  out  10  committed top edge
- dir_x / dir_y  out  1  1 = increasing coordinate
- frame_tick  out  1  one-cycle pulse on every commit
- in_sprite  out  1  registered: (hc,vc) inside committed box

## Operation
- vblank event: hc==0 && vc==VACTIVE, registered into vb_evt (one cycle high per frame).
- frame_cnt (8 b) increments on vb_evt, wraps FRAME_DIV-1 -> 0; update due on the wrap event when run=1 or step_pend=1.
- step_pend set on rising edge of step_req while run=0; cleared at COMMIT; ignored while run=1. A new step needs step_req low then high.
- FSM: IDLE -> CALC on vb_evt && due; CALC -> COMMIT unconditionally; COMMIT -> IDLE unconditionally. vb_evt in CALC/COMMIT cannot occur (one event per frame).
- CALC: per axis, 11-bit arithmetic into shadow regs; limit XMAX=HACTIVE-SPR_W, YMAX=VACTIVE-SPR_H.
- Bounce, dir=1: if pos+SPEED >= MAX then next=MAX, dir<=0, else pos+SPEED. dir=0: if pos <= SPEED then next=0, dir<=1, else pos-SPEED.
- COMMIT: shadow -> sprite_x/y, dir; frame_tick=1; step_ack=1 if the update came from step_pend.
- in_sprite = sprite_x<=hc<sprite_x+SPR_W && sprite_y<=vc<sprite_y+SPR_H, computed on committed values, registered.
- Reset values: sprite_x=X0, sprite_y=Y0, dir_x=dir_y=1, frame_tick=0, step_ack=0, in_sprite=0, frame_cnt=0, step_pend=0, FSM=IDLE, vb_evt=0.

## Timing
- Edge E0 samples hc=0,vc=VACTIVE; vb_evt high after E0; CALC after E1; COMMIT after E2; sprite_x/y, dir, frame_tick, step_ack change at E2 and hold for the COMMIT cycle; outputs stable until next commit.
- Commit completes 3 cycles into vblank: no mid-frame position change.
- in_sprite lags hc/vc by one cycle.
- Reset assertion mid-CALC/COMMIT: all state to reset values immediately; shadow discarded; first update at next due vblank after release.
- run toggling mid-frame affects only the next due event; run=1 and step_pend=1 together: one update, step_ack=1, step_pend cleared.

## Configuration
- MOTION_WRAP_EN defined: no bounce; dir never changes; dir=1 and pos+SPEED > MAX -> next=0; dir=0 and pos < SPEED -> next=MAX.
- Undefined: bounce rules above. dir outputs present in both builds.

## Structure
- Shared package vga_pkg: HACTIVE/VACTIVE/HTOTAL(800)/VTOTAL(525) constants, FSM state typedef (IDLE, CALC, COMMIT).
- Sub-module motion_axis: one axis's next-pos/next-dir function with MAX, SPEED inputs; instantiated for x and y.

## Test plan
- Reset, run=1, defaults: after 3 frames sprite_x=3, sprite_y=3, three frame_tick pulses, each at hc=2 of line 480.
- run=1, SPEED=4, X0=508 (XMAX=510): next commit sprite_x=510, dir_x=0; following commit 506.
- Y0=2, dir_y forced to 0 by prior bounce, SPEED=4: commit gives sprite_y=0, dir_y=1.
- run=0, step_req pulsed twice across 5 frames: exactly two commits, two step_ack, positions advance by SPEED each; step_req held high 5 frames: one commit.
- FRAME_DIV=3, run=1: commits only on every third vblank; rst_n low during CALC: sprite_x=X0, no frame_tick.
- MOTION_WRAP_EN, X0=510, dir_x=1: next commit sprite_x=0, dir_x stays 1; in_sprite high at (hc,vc)=(1,1) one cycle later.
